// File: rtl/logic_op_arbiter_pkg.sv
// Shared types and constants for the two-requester logic-op arbiter.
package logic_op_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_AND = 1'b1;
  localparam logic OP_OR  = 1'b0;

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the arbiter.
interface logic_op_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sel;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sel,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sel,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

endinterface

// File: rtl/logic_op_arbiter_logic_unit.sv
// Shared combinational AND/OR unit; exactly one instance lives in the arbiter.
module logic_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = (sel == OP_AND) ? (a & b) : (a | b);

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational, handshake latches operands
// EXEC  | shared unit evaluates latched operands; result registered at end of cycle
// RESP  | rsp_valid high, result held until rsp_ready
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_op_arbiter_if.slave bus,
  output logic [CNT_W-1:0] ops_done
);

  state_t           state_q;
  state_t           state_d;
  logic             last_id_q;
  logic             grant;
  logic             idle_ok;
  logic             accept;
  logic             rsp_valid_c;
  logic             rsp_done;
  logic             exec_c;

  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_sel_q;
  logic             op_id_q;
  logic [WIDTH-1:0] unit_y;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_id_q;
  logic [CNT_W-1:0] ops_done_q;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_id_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // rst_n gates ready so neither requester sees a handshake while in reset.
  assign idle_ok        = (state_q == IDLE) && rst_n;
  assign bus.req0_ready = idle_ok && !grant && bus.req0_valid;
  assign bus.req1_ready = idle_ok &&  grant && bus.req1_valid;
  assign accept         = bus.req0_ready || bus.req1_ready;

  always_comb begin
    state_d     = state_q;
    rsp_valid_c = 1'b0;
    rsp_done    = 1'b0;
    exec_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        exec_c  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_sel_q  <= OP_OR;
      op_id_q   <= 1'b0;
      last_id_q <= 1'b1;
    end else if (accept) begin
      op_a_q    <= grant ? bus.req1_a   : bus.req0_a;
      op_b_q    <= grant ? bus.req1_b   : bus.req0_b;
      op_sel_q  <= grant ? bus.req1_sel : bus.req0_sel;
      op_id_q   <= grant;
      last_id_q <= grant;
    end
  end

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .a   (op_a_q),
    .b   (op_b_q),
    .sel (op_sel_q),
    .y   (unit_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else if (exec_c) begin
      rsp_data_q <= unit_y;
      rsp_id_q   <= op_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done_q <= '0;
    end else if (rsp_done) begin
      ops_done_q <= ops_done_q + CNT_W'(1);
    end
  end

  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed scenarios plus a randomized scoreboard run.
module tb_logic_op_arbiter;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] ops_done;

  logic_op_arbiter_if #(.WIDTH(W)) bus ();

  logic_op_arbiter #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic m_last_id;
  int   m_ops;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sel);
    return sel ? (a & b) : (a | b);
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = 1'b0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last_id = 1'b1;
    m_ops = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b000 || ops_done !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold: ready0=%b ready1=%b rsp_valid=%b ops_done=%0d expected all 0",
               bus.req0_ready, bus.req1_ready, bus.rsp_valid, ops_done);
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_data} !== 5'b0) begin
      errors++;
      $display("FAIL reset_rsp: rsp_id=%b rsp_data=%b expected 0", bus.rsp_id, bus.rsp_data);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last_id = 1'b1;
    m_ops = 0;
    repeat (5) begin
      @(negedge clk); #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b000 || ops_done !== 2'd0) begin
        errors++;
        $display("FAIL reset_idle: ready0=%b ready1=%b rsp_valid=%b ops_done=%0d expected all 0",
                 bus.req0_ready, bus.req1_ready, bus.rsp_valid, ops_done);
      end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 4'b1100; bus.req0_b = 4'b1010; bus.req0_sel = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: ready0/1=%b%b expected 10", bus.req0_ready, bus.req1_ready);
    end
    m_last_id = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL single_exec: ready0=%b ready1=%b rsp_valid=%b expected 000",
               bus.req0_ready, bus.req1_ready, bus.rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 ||
        bus.rsp_data !== ref_op(4'b1100, 4'b1010, 1'b1)) begin
      errors++;
      $display("FAIL single_rsp: valid=%b id=%b data=%b expected 1 0 %b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, ref_op(4'b1100, 4'b1010, 1'b1));
    end
    bus.rsp_ready = 1'b1;
    m_ops++;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || ops_done !== CW'(m_ops)) begin
      errors++;
      $display("FAIL single_done: rsp_valid=%b ops_done=%0d expected 0 %0d",
               bus.rsp_valid, ops_done, CW'(m_ops));
    end
  endtask

  task automatic test_alternate();
    int   n = 0;
    int   last_cyc = 0;
    logic exp_id;
    logic [W-1:0] exp_data;
    reset_dut();
    exp_id = ~m_last_id;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 4'b0011; bus.req0_b = 4'b0101; bus.req0_sel = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'hF;    bus.req1_b = 4'h6;    bus.req1_sel = 1'b1;
    bus.rsp_ready  = 1'b1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      #1;
      if (bus.rsp_valid) begin
        exp_data = exp_id ? ref_op(4'hF, 4'h6, 1'b1) : ref_op(4'b0011, 4'b0101, 1'b0);
        checks++;
        if (bus.rsp_id !== exp_id || bus.rsp_data !== exp_data) begin
          errors++;
          $display("FAIL alt_rsp%0d: id=%b data=%b expected %b %b",
                   n, bus.rsp_id, bus.rsp_data, exp_id, exp_data);
        end
        if (n > 0) begin
          checks++;
          if (c - last_cyc != 3) begin
            errors++;
            $display("FAIL alt_interval%0d: %0d cycles expected 3", n, c - last_cyc);
          end
        end
        last_cyc  = c;
        m_last_id = exp_id;
        exp_id    = ~exp_id;
        m_ops++;
        n++;
      end
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL alt_count: %0d responses expected 4", n);
    end
    #1;
    checks++;
    if (ops_done !== CW'(m_ops)) begin
      errors++;
      $display("FAIL alt_ops_done: %0d expected %0d", ops_done, CW'(m_ops));
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, exp_data;
    logic         s;
    int           w;
    a = W'($urandom); b = W'($urandom); s = 1'($urandom);
    exp_data = ref_op(a, b, s);
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = s;
    bus.rsp_ready  = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_grant: ready0/1=%b%b expected 01", bus.req0_ready, bus.req1_ready);
    end
    m_last_id = 1'b1;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
    #1;
    for (w = 0; w < 4 && !bus.rsp_valid; w++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: rsp_valid=%b expected 1 within 4 cycles", bus.rsp_valid);
    end
    repeat (4) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== exp_data ||
          {bus.req0_ready, bus.req1_ready} !== 2'b00 || ops_done !== CW'(m_ops)) begin
        errors++;
        $display("FAIL bp_hold: valid=%b id=%b data=%b rdy=%b%b ops=%0d expected 1 1 %b 00 %0d",
                 bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req0_ready, bus.req1_ready,
                 ops_done, exp_data, CW'(m_ops));
      end
      @(negedge clk); #1;
    end
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    m_ops++;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || ops_done !== CW'(m_ops)) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b ops_done=%0d expected 0 %0d",
               bus.rsp_valid, ops_done, CW'(m_ops));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
    bus.req0_sel = 1'($urandom);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rm_grant: ready0/1=%b%b expected 10", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
      errors++;
      $display("FAIL rm_exec_reset: rsp_valid=%b ready0=%b ready1=%b expected 000",
               bus.rsp_valid, bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_last_id = 1'b1;
    m_ops = 0;
    repeat (4) begin
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || ops_done !== 2'd0) begin
        errors++;
        $display("FAIL rm_discard: rsp_valid=%b ops_done=%0d expected 0 0",
                 bus.rsp_valid, ops_done);
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b1; bus.req0_a = 4'b1001; bus.req0_b = 4'b0110; bus.req0_sel = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'b1111; bus.req1_b = 4'b0000; bus.req1_sel = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rm_contention: ready0/1=%b%b expected 10", bus.req0_ready, bus.req1_ready);
    end
    m_last_id = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 ||
        bus.rsp_data !== ref_op(4'b1001, 4'b0110, 1'b0)) begin
      errors++;
      $display("FAIL rm_rsp: valid=%b id=%b data=%b expected 1 0 %b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, ref_op(4'b1001, 4'b0110, 1'b0));
    end
    m_ops++;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
    #1;
    checks++;
    if (ops_done !== CW'(m_ops) || {bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rm_after: ops_done=%0d ready0/1=%b%b expected %0d 01",
               ops_done, bus.req0_ready, bus.req1_ready, CW'(m_ops));
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || ops_done !== 2'd0) begin
      errors++;
      $display("FAIL rm_resp_reset: rsp_valid=%b ops_done=%0d expected 0 0",
               bus.rsp_valid, ops_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_last_id = 1'b1;
    m_ops = 0;
  endtask

  task automatic test_wrap();
    int           exp_seq [5] = '{1, 2, 3, 0, 1};
    logic [W-1:0] a, b;
    logic         s;
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = s;
      bus.rsp_ready  = 1'b1;
      @(negedge clk);
      bus.req0_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ref_op(a, b, s)) begin
        errors++;
        $display("FAIL wrap_rsp%0d: valid=%b data=%b expected 1 %b",
                 k, bus.rsp_valid, bus.rsp_data, ref_op(a, b, s));
      end
      m_ops++;
      @(negedge clk); #1;
      checks++;
      if (ops_done !== CW'(exp_seq[k])) begin
        errors++;
        $display("FAIL wrap_ops%0d: ops_done=%0d expected %0d", k, ops_done, exp_seq[k]);
      end
    end
    m_last_id = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic         pend [2];
    logic [W-1:0] pa [2];
    logic [W-1:0] pb [2];
    logic         ps [2];
    logic         busy = 1'b0;
    int           acc_cyc = 0;
    logic         exp_id = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         g, e_r0, e_r1, e_rv;
    reset_dut();
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = W'($urandom); pb[i] = W'($urandom); ps[i] = 1'($urandom);
        end
      end
      bus.req0_valid = pend[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0]; bus.req0_sel = ps[0];
      bus.req1_valid = pend[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1]; bus.req1_sel = ps[1];
      bus.rsp_ready  = 1'($urandom);
      #1;
      g    = (pend[0] && pend[1]) ? ~m_last_id : pend[1];
      e_r0 = !busy && pend[0] && !g;
      e_r1 = !busy && pend[1] &&  g;
      e_rv = busy && (c >= acc_cyc + 2);
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {e_r0, e_r1}) begin
        errors++;
        $display("FAIL rnd_ready c%0d: ready0/1=%b%b expected %b%b",
                 c, bus.req0_ready, bus.req1_ready, e_r0, e_r1);
      end
      checks++;
      if (bus.rsp_valid !== e_rv || ops_done !== CW'(m_ops)) begin
        errors++;
        $display("FAIL rnd_valid c%0d: rsp_valid=%b ops_done=%0d expected %b %0d",
                 c, bus.rsp_valid, ops_done, e_rv, CW'(m_ops));
      end
      if (e_rv) begin
        checks++;
        if (bus.rsp_id !== exp_id || bus.rsp_data !== exp_data) begin
          errors++;
          $display("FAIL rnd_rsp c%0d: id=%b data=%b expected %b %b",
                   c, bus.rsp_id, bus.rsp_data, exp_id, exp_data);
        end
        if (bus.rsp_ready) begin
          busy = 1'b0;
          m_ops++;
        end
      end
      if (e_r0 || e_r1) begin
        busy      = 1'b1;
        acc_cyc   = c;
        exp_id    = e_r1;
        exp_data  = ref_op(pa[e_r1], pb[e_r1], ps[e_r1]);
        m_last_id = e_r1;
        pend[e_r1] = 1'b0;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_op_arbiter.md
# logic_op_arbiter

Shares one AND/OR logic unit between two requesters. Each requester presents operands `a` and `b` plus an operation select through a valid/ready handshake. The block arbitrates round-robin between the two, runs the accepted operation on the shared unit and returns a registered result tagged with the requester ID. It sits between the requester-side control logic and the combinational logic unit, and is the only block that drives that unit.

## Interface
- `WIDTH`, default 1: operand and result width; the operation is applied bitwise.
- `CNT_W`, default 8: width of the completed-operation counter.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req0_sel`  in  1  requester 0 operation: 1 = AND, 0 = OR.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: the same signals for requester 1.
- `rsp_valid`  out  1  a result is available.
- `rsp_ready`  in  1  the consumer takes the result.
- `rsp_id`  out  1  which requester the result belongs to.
- `rsp_data`  out  WIDTH  the result.
- `ops_done`  out  CNT_W  count of completed responses; wraps modulo 2^CNT_W.

## Operation
- State machine with three states: `IDLE`, `EXEC`, `RESP`.
- **IDLE**
  - `grant` is combinational. With exactly one valid requester, that requester is granted.
  - With both valid, the requester that is not `last_id` is granted.
  - `reqN_ready = (state==IDLE) & grant==N & reqN_valid`.
  - A handshake (valid & ready) at a rising edge does three things: latches a, b, sel and id into operand registers, sets `last_id` to the accepted id, and moves to EXEC.
- **EXEC**
  - The shared unit computes `rsp_data = sel ? (a & b) : (a | b)` from the latched operands.
  - The result is registered into `rsp_data` and `rsp_id` at the end of the cycle.
  - State moves to RESP.
- **RESP**
  - `rsp_valid = 1`.
  - When `rsp_ready` is high at a rising edge: `ops_done` increments, state returns to IDLE, and `rsp_valid` falls on the next cycle.
  - While `rsp_ready` is low, state stays RESP and `rsp_data` and `rsp_id` hold stable.
- Requesters hold valid and operands stable until ready. A requester that drops valid before being granted has no effect.
- Both `reqN_ready` signals are 0 outside IDLE; new requests wait.
- Only one operation is in flight at a time; there is no queuing.

## Timing
- Reset values:
  - state = IDLE, `last_id` = 1, so requester 0 wins the first contention.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `ops_done` = 0.
  - Both `reqN_ready` = 0 while `rst_n` is low.
- Latency: request accepted at edge T → `rsp_valid` high from T+2. Minimum issue interval is 3 cycles with `rsp_ready` tied high.
- Simultaneous valid on both requesters with `last_id` = 0 → grant to 1; with `last_id` = 1 → grant to 0.
- `ops_done` wraps from 2^CNT_W−1 to 0 with no flag.
- Reset asserted mid-operation, in EXEC or RESP: return to IDLE immediately. The pending operation is discarded and `rsp_valid` drops asynchronously.
- `rsp_ready` high outside RESP is ignored.

## Structure
- The shared package `logic_op_pkg` holds:
  - the state enum (`IDLE`, `EXEC`, `RESP`);
  - the operation-select constants `OP_AND = 1'b1` and `OP_OR = 1'b0`.
- Sub-module `logic_unit`, parameterized by WIDTH and purely combinational: inputs a, b, sel; output `sel ? a&b : a|b`. It is the shared resource and is instantiated once.
- The arbiter holds the operand registers, state register, `last_id`, result register and counter.

## Test plan
- Reset, then no requests for 5 cycles → `rsp_valid` = 0, both ready = 0, `ops_done` = 0.
- WIDTH=4, `req0` a=4'b1100 b=4'b1010 sel=1 alone → ready0 pulses once; 2 cycles later `rsp_valid` = 1, `rsp_id` = 0, `rsp_data` = 4'b1000.
- Both valid continuously, `req0` (a=4'b0011, b=4'b0101, sel=0) and `req1` (a=4'hF, b=4'h6, sel=1), `rsp_ready` = 1:
  - responses alternate id 0, 1, 0, 1;
  - data alternates 4'b0111, 4'b0110;
  - one response every 3 cycles.
- `rsp_ready` held low 4 cycles in RESP → `rsp_valid`, `rsp_data` and `rsp_id` stable; both ready = 0; `ops_done` unchanged until the handshake.
- `rst_n` pulsed low during EXEC → `rsp_valid` never rises for that operation; the next contention grants requester 0.
- CNT_W=2, 5 completed operations → `ops_done` sequence 1, 2, 3, 0, 1.
